// File: rtl/ball_motion.sv
// ball_motion: breakout ball that rests on the paddle, flies diagonally and
// reflects off walls, bricks and the paddle. It also keeps the lives count.
// Ports: clock, reset (async, active-low), move_tick (step strobe),
//   launch (level), paddle_col[3:0] (clamped to 12), bricks[55:0] (row 1..7 map)
//   -> ball_row[3:0], ball_col[3:0], ball_dir[1:0] ({down, left}),
//   ball_valid (in flight), lives[1:0], game_over.
// Option: define BALL_SPEEDUP_EN so that, once the ball has made 8 or more
//   paddle hits, it steps on every move_tick instead of every second one.
module ball_motion (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_tick,
    input  logic        launch,
    input  logic [3:0]  paddle_col,
    input  logic [55:0] bricks,
    output logic [3:0]  ball_row,
    output logic [3:0]  ball_col,
    output logic [1:0]  ball_dir,
    output logic        ball_valid,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, MOVE, LOST, OVER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  hits_q, hits_d;
    logic        div_q, div_d;

    logic [3:0]  pcl;
    logic        fast;
    logic        step;
    logic        h_r;
    logic        v_r;
    logic [3:0]  ncol;
    logic [3:0]  nrow;
    logic [2:0]  rm2;
    logic [5:0]  bidx;
    logic        brick_hit;
    logic        pad_hit;
    logic        at_pad;
    logic        lost;

    assign pcl = (paddle_col > 4'd12) ? 4'd12 : paddle_col;

`ifdef BALL_SPEEDUP_EN
    assign fast = hits_q[3];
`else
    assign fast = 1'b0;
`endif

    assign step = (state_q == MOVE) && move_tick && (div_q || fast);

    // Horizontal wall reflection comes first; the paddle test uses its result.
    assign h_r  = dir_q[0] ^ ((!dir_q[0] && col_q == 4'd15) ||
                              (dir_q[0] && col_q == 4'd0));
    assign ncol = h_r ? col_q - 4'd1 : col_q + 4'd1;

    // Brick above the ball: (row-1) in 1..7 means row in 2..8.
    assign rm2       = row_q[2:0] - 3'd2;
    assign bidx      = {rm2, col_q[3:1]};
    assign brick_hit = (row_q >= 4'd2) && (row_q <= 4'd8) && bricks[bidx];

    assign pad_hit = (ncol >= pcl) &&
                     ({1'b0, ncol} <= ({1'b0, pcl} + 5'd3));
    assign at_pad  = dir_q[1] && (row_q == 4'd14);
    assign lost    = at_pad && !pad_hit;

    always_comb begin
        v_r = dir_q[1];
        if (!dir_q[1]) begin
            v_r = (row_q == 4'd0) || brick_hit;
        end else if (row_q == 4'd14) begin
            v_r = !pad_hit;
        end
    end

    assign nrow = v_r ? row_q + 4'd1 : row_q - 4'd1;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        lives_d = lives_q;
        hits_d  = hits_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                row_d = 4'd14;
                col_d = pcl + 4'd2;
                if (move_tick && launch) begin
                    dir_d   = 2'b00;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (move_tick) begin
                    div_d = ~div_q;
                end
                if (step) begin
                    row_d = nrow;
                    col_d = ncol;
                    dir_d = {v_r, h_r};
                    if (at_pad && pad_hit && hits_q != 4'hF) begin
                        hits_d = hits_q + 4'd1;
                    end
                    if (lost) begin
                        state_d = LOST;
                    end
                end
            end
            LOST: begin
                lives_d = lives_q - 2'd1;
                hits_d  = 4'd0;
                div_d   = 1'b0;
                state_d = (lives_q == 2'd1) ? OVER : IDLE;
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= 4'd14;
            col_q   <= 4'd7;
            dir_q   <= 2'b00;
            lives_q <= 2'd3;
            hits_q  <= 4'd0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dir_q   <= dir_d;
            lives_q <= lives_d;
            hits_q  <= hits_d;
            div_q   <= div_d;
        end
    end

    assign ball_row   = row_q;
    assign ball_col   = col_q;
    assign ball_dir   = dir_q;
    assign ball_valid = (state_q == MOVE);
    assign lives      = lives_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed trajectories plus random play against a
// behavioural ball model; every output compared on each falling edge.
module tb_ball_motion;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        move_tick = 1'b0;
    logic        launch = 1'b0;
    logic [3:0]  paddle_col = 4'd5;
    logic [55:0] bricks = '0;
    logic [3:0]  ball_row;
    logic [3:0]  ball_col;
    logic [1:0]  ball_dir;
    logic        ball_valid;
    logic [1:0]  lives;
    logic        game_over;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    localparam int S_REST = 0;
    localparam int S_FLY  = 1;
    localparam int S_LOST = 2;
    localparam int S_OVER = 3;

    int m_st, m_row, m_col, m_down, m_left, m_lives, m_hits, m_ticks;

    ball_motion dut (
        .clock(clock), .reset(reset), .move_tick(move_tick),
        .launch(launch), .paddle_col(paddle_col), .bricks(bricks),
        .ball_row(ball_row), .ball_col(ball_col), .ball_dir(ball_dir),
        .ball_valid(ball_valid), .lives(lives), .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int brick_at(int r, int c);
        if (r < 1 || r > 7) return 0;
        return int'(bricks[(r - 1) * 8 + c / 2]);
    endfunction

    task automatic model_reset();
        m_st = S_REST; m_row = 14; m_col = 7; m_down = 0; m_left = 0;
        m_lives = 3; m_hits = 0; m_ticks = 0;
    endtask

    task automatic model_step(input int pcl);
        int nc;
        bit gone;
        gone = 0;
        if (!m_left && m_col == 15) m_left = 1;
        else if (m_left && m_col == 0) m_left = 0;
        nc = m_left ? m_col - 1 : m_col + 1;
        if (!m_down) begin
            if (m_row == 0 || brick_at(m_row - 1, m_col) != 0) m_down = 1;
        end else if (m_row == 14) begin
            if (nc >= pcl && nc <= pcl + 3) begin
                m_down = 0;
                if (m_hits < 15) m_hits++;
            end else begin
                gone = 1;
            end
        end
        m_row = m_down ? m_row + 1 : m_row - 1;
        m_col = nc;
        if (gone) m_st = S_LOST;
    endtask

    task automatic model_edge();
        int pcl;
        bit fast;
        pcl = (int'(paddle_col) > 12) ? 12 : int'(paddle_col);
`ifdef BALL_SPEEDUP_EN
        fast = (m_hits >= 8);
`else
        fast = 0;
`endif
        case (m_st)
            S_REST: begin
                m_row = 14;
                m_col = pcl + 2;
                if (move_tick && launch) begin
                    m_down = 0; m_left = 0; m_st = S_FLY;
                end
            end
            S_FLY: begin
                if (move_tick) begin
                    bit st;
                    st = (m_ticks % 2 == 1) || fast;
                    m_ticks++;
                    if (st) model_step(pcl);
                end
            end
            S_LOST: begin
                m_lives--;
                m_hits = 0;
                m_ticks = 0;
                m_st = (m_lives == 0) ? S_OVER : S_REST;
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("row", int'(ball_row), m_row);
            chk("col", int'(ball_col), m_col);
            chk("dir", int'(ball_dir), m_down * 2 + m_left);
            chk("valid", int'(ball_valid), int'(m_st == S_FLY));
            chk("lives", int'(lives), m_lives);
            chk("over", int'(game_over), int'(m_st == S_OVER));
        end
    end

    task automatic drive(input logic mt, input logic ln, input logic [3:0] pc);
        move_tick = mt;
        launch = ln;
        paddle_col = pc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_steps(input int n, input logic [3:0] pc);
        repeat (n) begin
            drive(1'b1, 1'b0, pc);
            drive(1'b1, 1'b0, pc);
        end
    endtask

    task automatic chk_pos(input string nm, input int r, input int c, input int d);
        chk({nm, "_row"}, int'(ball_row), r);
        chk({nm, "_col"}, int'(ball_col), c);
        chk({nm, "_dir"}, int'(ball_dir), d);
        chk({nm, "_mrow"}, m_row, r);
        chk({nm, "_mcol"}, m_col, c);
        chk({nm, "_mdir"}, m_down * 2 + m_left, d);
    endtask

    task automatic restart(input logic [3:0] pc);
        reset = 1'b0;
        drive(1'b0, 1'b0, pc);
        reset = 1'b1;
        drive(1'b0, 1'b0, pc);
    endtask

    task automatic play_until_lost(input string nm);
        int budget;
        budget = 0;
        drive(1'b1, 1'b1, 4'd0);
        while (m_st != S_LOST && budget < 3000) begin
            drive(1'b1, 1'b0, (m_col < 8) ? 4'd12 : 4'd0);
            budget++;
        end
        chk({nm, "_reached_lost"}, int'(ball_row), 15);
        drive(1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        logic [63:0] rb;
        @(posedge clock);
        #1;
        chk_pos("reset", 14, 7, 0);
        chk("reset_lives", int'(lives), 3);
        chk("reset_valid", int'(ball_valid), 0);
        chk("reset_over", int'(game_over), 0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd5);
        chk_pos("idle_p5", 14, 7, 0);
        drive(1'b0, 1'b0, 4'd14);
        chk_pos("idle_p14", 14, 14, 0);
        drive(1'b0, 1'b0, 4'd5);
        drive(1'b1, 1'b1, 4'd5);
        chk_pos("launch", 14, 7, 0);
        chk("launch_valid", int'(ball_valid), 1);
        do_steps(1, 4'd5);
        chk_pos("step1", 13, 8, 0);
        do_steps(1, 4'd5);
        chk_pos("step2", 12, 9, 0);

        restart(4'd0);
        drive(1'b1, 1'b1, 4'd0);
        chk_pos("launch2", 14, 2, 0);
        do_steps(13, 4'd0);
        chk_pos("near_corner", 1, 15, 0);
        do_steps(1, 4'd0);
        chk_pos("right_wall", 0, 14, 1);
        do_steps(1, 4'd0);
        chk_pos("top_wall", 1, 13, 3);
        do_steps(13, 4'd0);
        chk_pos("at_paddle", 14, 0, 3);
        do_steps(1, 4'd0);
        chk_pos("paddle_corner", 13, 1, 0);
        do_steps(13, 4'd0);
        chk_pos("top_again", 0, 14, 0);
        do_steps(1, 4'd0);
        chk_pos("top_bounce", 1, 15, 2);
        do_steps(1, 4'd0);
        chk_pos("right_bounce", 2, 14, 3);
        do_steps(12, 4'd8);
        chk_pos("above_gap", 14, 2, 3);
        do_steps(1, 4'd8);
        chk_pos("fell", 15, 1, 3);
        chk("fell_valid", int'(ball_valid), 0);
        chk("fell_lives", int'(lives), 3);
        drive(1'b0, 1'b0, 4'd8);
        chk("lost_lives", int'(lives), 2);
        chk("lost_over", int'(game_over), 0);
        drive(1'b0, 1'b0, 4'd8);
        chk_pos("back_idle", 14, 10, 3);

        bricks = 56'd1 << 14;
        restart(4'd0);
        drive(1'b1, 1'b1, 4'd0);
        do_steps(11, 4'd0);
        chk_pos("below_brick", 3, 13, 0);
        do_steps(1, 4'd0);
        chk_pos("brick_bounce", 4, 14, 2);

        bricks = '0;
        restart(4'd0);
        play_until_lost("g1");
        chk("g1_lives", int'(lives), 2);
        play_until_lost("g2");
        chk("g2_lives", int'(lives), 1);
        play_until_lost("g3");
        chk("g3_lives", int'(lives), 0);
        chk("g3_over", int'(game_over), 1);
        repeat (4) drive(1'b1, 1'b1, 4'd5);
        chk("over_frozen_row", int'(ball_row), 15);
        chk("over_hold", int'(game_over), 1);
        chk("over_valid", int'(ball_valid), 0);
        restart(4'd3);
        chk("over_reset", int'(game_over), 0);
        chk("over_reset_lives", int'(lives), 3);

        for (int i = 0; i < 20000; i++) begin
            logic mt, ln;
            logic [3:0] pc;
            int t;
            if ($urandom % 1500 == 0 ||
                (m_st == S_OVER && $urandom % 30 == 0)) begin
                reset = 1'b0;
                rb = {$urandom, $urandom} & {$urandom, $urandom};
                bricks = ($urandom % 3 == 0) ? '0 : rb[55:0];
            end else begin
                reset = 1'b1;
            end
            mt = ($urandom % 3 != 0);
            ln = ($urandom % 4 == 0);
            if ($urandom % 4 != 0) begin
                t = m_col - int'($urandom_range(3, 0));
                if (t < 0) t = 0;
                pc = t[3:0];
            end else begin
                pc = 4'($urandom % 16);
            end
            drive(mt, ln, pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
